// File: rtl/alu_if.sv
// alu_if: operand/opcode request and registered result bundle for the ALU.
//   in1    WIDTH  operand A (sole operand for unary ops)
//   in2    WIDTH  operand B (ignored for unary ops)
//   select 3      opcode
//   result WIDTH  registered operation result
//   carry  1      registered carry/borrow/shift-out flag
//   zero   1      registered flag, 1 when result == 0
// master: the block issuing operations; slave: the ALU.
interface alu_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [2:0]       select;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;

    modport master (
        output in1,
        output in2,
        output select,
        input  result,
        input  carry,
        input  zero
    );

    modport slave (
        input  in1,
        input  in2,
        input  select,
        output result,
        output carry,
        output zero
    );

endinterface

// File: rtl/alu.sv
// alu: registered ALU with one-cycle latency. The opcode on bus.select
// picks one of eight arithmetic/logic/shift ops on bus.in1/bus.in2; the
// result, carry and zero flags are captured on the rising edge of clk.
//   clk  1      clock, all state updates on rising edge
//   rst  1      synchronous active-high reset (result=0, carry=0, zero=1)
//   bus  alu_if.slave  operands/opcode in, result/carry/zero out
module alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    localparam int unsigned EXT_W = WIDTH + 1;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_IDEN = 3'b010,
        OP_LS   = 3'b011,
        OP_RS   = 3'b100,
        OP_AND  = 3'b101,
        OP_NOT  = 3'b110,
        OP_OR   = 3'b111
    } op_e;

    op_e              op_c;
    logic [EXT_W-1:0] sum_c;
    logic [EXT_W-1:0] diff_c;
    logic [WIDTH-1:0] result_nxt_c;
    logic             carry_nxt_c;

    assign op_c = op_e'(bus.select);

    // One extra bit captures carry-out; for subtraction it goes high
    // exactly when the unsigned difference wraps (in1 < in2).
    assign sum_c  = EXT_W'(bus.in1) + EXT_W'(bus.in2);
    assign diff_c = EXT_W'(bus.in1) - EXT_W'(bus.in2);

    // Next result/carry; unary ops never reference in2.
    always_comb begin
        result_nxt_c = '0;
        carry_nxt_c  = 1'b0;
        case (op_c)
            OP_ADD: begin
                result_nxt_c = sum_c[WIDTH-1:0];
                carry_nxt_c  = sum_c[WIDTH];
            end
            OP_SUB: begin
                result_nxt_c = diff_c[WIDTH-1:0];
                carry_nxt_c  = diff_c[WIDTH];
            end
            OP_IDEN: begin
                result_nxt_c = bus.in1;
            end
            OP_LS: begin
                {carry_nxt_c, result_nxt_c} = {bus.in1, 1'b0};
            end
            OP_RS: begin
                {result_nxt_c, carry_nxt_c} = {1'b0, bus.in1};
            end
            OP_AND: begin
                result_nxt_c = bus.in1 & bus.in2;
            end
            OP_NOT: begin
                result_nxt_c = ~bus.in1;
            end
            OP_OR: begin
                result_nxt_c = bus.in1 | bus.in2;
            end
            default: begin
                result_nxt_c = '0;
                carry_nxt_c  = 1'b0;
            end
        endcase
    end

    // Output registers; reset wins over any opcode in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result <= '0;
            bus.carry  <= 1'b0;
            bus.zero   <= 1'b1;
        end else begin
            bus.result <= result_nxt_c;
            bus.carry  <= carry_nxt_c;
            bus.zero   <= (result_nxt_c == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_if #(.WIDTH(WIDTH)) bus ();

    alu #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the opcode table using plain integer arithmetic.
    function automatic void model(input int sel, input int a, input int b,
                                  output int r, output int c, output int z);
        int t;
        c = 0;
        case (sel)
            0: begin t = a + b; r = t % 256; c = (t > 255) ? 1 : 0; end
            1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: r = a;
            3: begin r = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
            4: begin r = a / 2; c = a % 2; end
            5: r = a & b;
            6: r = 255 - a;
            default: r = a | b;
        endcase
        z = (r == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int r, input int c, input int z);
        chk({tag, ".result"}, bus.result, 8'(r));
        chk({tag, ".carry"},  {7'd0, bus.carry}, 8'(c));
        chk({tag, ".zero"},   {7'd0, bus.zero},  8'(z));
    endtask

    task automatic drive(input int sel, input int a, input int b);
        bus.select = 3'(sel);
        bus.in1    = 8'(a);
        bus.in2    = 8'(b);
    endtask

    // Apply an op at negedge, hold it for two edges, check after the second.
    task automatic op2(input string tag, input int sel, input int a, input int b,
                       input int er, input int ec, input int ez);
        @(negedge clk);
        drive(sel, a, b);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_out(tag, er, ec, ez);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int r, c, z, sel, a, b;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(0, 7, 9);

        // Reset held two edges
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;

        // Opcode sweep
        op2("add",  0, 204, 51,  255, 0, 0);
        op2("sub",  1, 170, 85,  85,  0, 0);
        op2("iden", 2, 240, 0,   240, 0, 0);
        op2("ls",   3, 85,  0,   170, 0, 0);
        op2("rs",   4, 51,  0,   25,  1, 0);
        op2("and",  5, 15,  240, 0,   0, 1);
        op2("not",  6, 255, 0,   0,   0, 1);
        op2("or",   7, 85,  170, 255, 0, 0);

        // Wrap-around
        op2("add_wrap", 0, 200, 100, 44,  1, 0);
        op2("sub_wrap", 1, 5,   10,  251, 1, 0);
        op2("add_ovf",  0, 255, 1,   0,   1, 1);

        // Shift edges
        op2("ls128", 3, 128, 0, 0,  1, 1);
        op2("rs1",   4, 1,   0, 0,  1, 1);
        op2("rs128", 4, 128, 0, 64, 0, 0);

        // Unary ops must ignore in2
        op2("not_in2", 6, 15, 123, 240, 0, 0);
        op2("ls_in2",  3, 3,  255, 6,   0, 0);

        // Latency: mid-cycle input change is invisible until the next edge
        @(negedge clk);
        drive(0, 10, 20);
        @(posedge clk);
        #1;
        chk_out("lat_edge", 30, 0, 0);
        @(negedge clk);
        drive(1, 50, 8);
        #2;
        chk_out("lat_hold", 30, 0, 0);
        @(posedge clk);
        #1;
        chk_out("lat_next", 42, 0, 0);

        // Reset mid-op discards in-flight ADD
        @(negedge clk);
        drive(0, 100, 100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_out("rst_midop", 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_out("rst_resume", 200, 0, 0);

        // Randomized ops, one per edge, with occasional reset
        for (int i = 0; i < 300; i++) begin
            logic do_rst;
            @(negedge clk);
            sel    = int'($urandom_range(0, 7));
            a      = int'($urandom_range(0, 255));
            b      = int'($urandom_range(0, 255));
            do_rst = ($urandom_range(0, 15) == 0);
            drive(sel, a, b);
            rst = do_rst;
            @(posedge clk);
            #1;
            if (do_rst) begin
                r = 0; c = 0; z = 1;
            end else begin
                model(sel, a, b, r, c, z);
            end
            chk_out($sformatf("rand%0d_sel%0d", i, sel), r, c, z);
        end
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
